nco_amp_detector: RTL and testbench

//  Receive-side counterpart of the NCO amplitude scaler. Measures the peak |sample| of a signed
//  ADC/DAC-domain stream over fixed windows of 2^WIN_LOG2 valid samples, then recovers the

---
 rtl/nco_amp_detector_if.sv | 26 ++
 rtl/nco_amp_detector.sv | 178 +++++++++++++++++
 tb/tb_nco_amp_detector.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nco_amp_detector_if.sv
// Sample/result bundle for the NCO amplitude detector.
// The master drives the sample stream and full-scale reference; the slave (detector) drives results.
interface nco_amp_detector_if #(
   parameter int DAC_WIDTH = 14,
   parameter int IN_WIDTH  = 14
);
   logic                        ADC_VALID;
   logic signed [DAC_WIDTH-1:0] ADC_DATA;
   logic signed [DAC_WIDTH-1:0] MAX_VOLTAGE;
   logic        [DAC_WIDTH-1:0] PEAK;
   logic signed [IN_WIDTH-1:0]  FRAC;
   logic                        AMP_VALID;
   logic                        SAT;
   logic                        BUSY;
   logic                        OVERRUN;

   modport master (
      output ADC_VALID, ADC_DATA, MAX_VOLTAGE,
      input  PEAK, FRAC, AMP_VALID, SAT, BUSY, OVERRUN
   );

   modport slave (
      input  ADC_VALID, ADC_DATA, MAX_VOLTAGE,
      output PEAK, FRAC, AMP_VALID, SAT, BUSY, OVERRUN
   );
endinterface

// File: rtl/nco_amp_detector.sv
// Windowed peak-magnitude detector with a sequential restoring divider that turns the
// window peak into a normalised amplitude code FRAC = PEAK * 2^(IN_WIDTH-1) / MAX_VOLTAGE.
module nco_amp_detector #(
   parameter int DAC_WIDTH = 14,
   parameter int IN_WIDTH  = 14,
   parameter int WIN_LOG2  = 4
) (
   input  logic              clk,
   input  logic              rst,
   nco_amp_detector_if.slave bus
);
   localparam int QW = IN_WIDTH - 1;                      // quotient bits
   localparam int RW = DAC_WIDTH + 1;                     // shifted-remainder width
   localparam int BW = (QW > 1) ? $clog2(QW) : 1;         // bit-counter width
   localparam logic [BW-1:0]        LAST_BIT = BW'(QW - 1);
   localparam logic [DAC_WIDTH-1:0] MAG_MAX  = {1'b0, {(DAC_WIDTH-1){1'b1}}};
   localparam logic [DAC_WIDTH-1:0] MOST_NEG = {1'b1, {(DAC_WIDTH-1){1'b0}}};
   localparam logic [IN_WIDTH-1:0]  FRAC_MAX = {1'b0, {QW{1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

   state_t state_q, state_d;
   logic   load, step, finish, busy;

   // Window accumulator
   logic [WIN_LOG2-1:0]  cnt_q, cnt_d;
   logic [DAC_WIDTH-1:0] run_peak_q, run_peak_d;

   // Divider working set
   logic [DAC_WIDTH-1:0] div_peak_q, div_peak_d;
   logic [DAC_WIDTH-1:0] divisor_q, divisor_d;
   logic                 div_sat_q, div_sat_d;
   logic [DAC_WIDTH-1:0] rem_q, rem_d;
   logic [QW-1:0]        quo_q, quo_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;

   // Published results
   logic [DAC_WIDTH-1:0] peak_q, peak_d;
   logic [IN_WIDTH-1:0]  frac_q, frac_d;
   logic                 sat_q, sat_d;
   logic                 amp_valid_q, amp_valid_d;
   logic                 overrun_q, overrun_d;

   logic [DAC_WIDTH-1:0] sample_mag;
   logic [DAC_WIDTH-1:0] peak_upd;
   logic                 win_end;
   logic                 sat_now;
   logic [RW-1:0]        rem_shift;
   logic                 rem_ge;

   // The most negative code has no positive twin, so it clips to the largest magnitude.
   assign sample_mag = !bus.ADC_DATA[DAC_WIDTH-1]     ? $unsigned(bus.ADC_DATA) :
                       (bus.ADC_DATA == MOST_NEG)      ? MAG_MAX :
                                                         $unsigned(-bus.ADC_DATA);
   assign peak_upd   = (sample_mag > run_peak_q) ? sample_mag : run_peak_q;
   assign win_end    = bus.ADC_VALID && (cnt_q == '1);
   // A non-positive reference or a peak at/above it cannot be represented below full scale.
   assign sat_now    = bus.MAX_VOLTAGE[DAC_WIDTH-1] || (bus.MAX_VOLTAGE == '0) ||
                       (peak_upd >= $unsigned(bus.MAX_VOLTAGE));
   assign rem_shift  = {rem_q, 1'b0};
   assign rem_ge     = rem_shift >= {1'b0, divisor_q};

   // Control FSM: sequences load, IN_WIDTH-1 divide steps, then one publish cycle.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      busy    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (win_end) begin
               load    = 1'b1;
               state_d = S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            busy = 1'b1;
            step = 1'b1;
            if (bit_cnt_q == LAST_BIT) state_d = S_DONE;
         end
         S_DONE: begin
            busy    = 1'b1;
            finish  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next state: accumulator, divider iteration and result publication.
   always_comb begin
      cnt_d       = cnt_q;
      run_peak_d  = run_peak_q;
      div_peak_d  = div_peak_q;
      divisor_d   = divisor_q;
      div_sat_d   = div_sat_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      bit_cnt_d   = bit_cnt_q;
      peak_d      = peak_q;
      frac_d      = frac_q;
      sat_d       = sat_q;
      amp_valid_d = finish;
      // A window closing while the divider is occupied is dropped and flagged until reset.
      overrun_d   = overrun_q | (win_end & busy);

      if (bus.ADC_VALID) begin
         cnt_d      = cnt_q + WIN_LOG2'(1);
         run_peak_d = win_end ? '0 : peak_upd;
      end

      if (load) begin
         div_peak_d = peak_upd;
         divisor_d  = $unsigned(bus.MAX_VOLTAGE);
         div_sat_d  = sat_now;
         rem_d      = peak_upd;
         quo_d      = '0;
         bit_cnt_d  = '0;
      end

      if (step) begin
         rem_d     = rem_ge ? DAC_WIDTH'(rem_shift - {1'b0, divisor_q}) : rem_shift[DAC_WIDTH-1:0];
         quo_d     = {quo_q[QW-2:0], rem_ge};
         bit_cnt_d = bit_cnt_q + BW'(1);
      end

      if (finish) begin
         peak_d = div_peak_q;
         frac_d = div_sat_q ? FRAC_MAX : {1'b0, quo_q};
         sat_d  = div_sat_q;
      end
   end

   // Control and result registers with synchronous reset; reset aborts any divide in flight.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         run_peak_q  <= '0;
         peak_q      <= '0;
         frac_q      <= '0;
         sat_q       <= 1'b0;
         amp_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         run_peak_q  <= run_peak_d;
         peak_q      <= peak_d;
         frac_q      <= frac_d;
         sat_q       <= sat_d;
         amp_valid_q <= amp_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   // Divider working registers.
   always_ff @(posedge clk) begin
      // NOTE: no reset here; these are always reloaded on window end before they are read.
      div_peak_q <= div_peak_d;
      divisor_q  <= divisor_d;
      div_sat_q  <= div_sat_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      bit_cnt_q  <= bit_cnt_d;
   end

   assign bus.PEAK      = peak_q;
   assign bus.FRAC      = frac_q;
   assign bus.SAT       = sat_q;
   assign bus.AMP_VALID = amp_valid_q;
   assign bus.BUSY      = busy;
   assign bus.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_nco_amp_detector.sv
// Bench for nco_amp_detector: two instances (16- and 4-sample windows) share one stimulus
// stream and are compared against a window-level reference model plus directed scenarios.
module tb_nco_amp_detector;
   localparam int DW   = 14;
   localparam int IW   = 14;
   localparam int FS   = 1 << (IW - 1);          // FRAC full scale (1.0)
   localparam int FMAX = FS - 1;                 // largest FRAC code
   localparam int DNEG = -(1 << (DW - 1));       // most negative sample
   localparam int DMAX = (1 << (DW - 1)) - 1;    // largest magnitude

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;

   nco_amp_detector_if #(.DAC_WIDTH(DW), .IN_WIDTH(IW)) b0 ();
   nco_amp_detector_if #(.DAC_WIDTH(DW), .IN_WIDTH(IW)) b1 ();

   nco_amp_detector #(.DAC_WIDTH(DW), .IN_WIDTH(IW), .WIN_LOG2(4)) u_dut16 (
      .clk(clk), .rst(rst), .bus(b0)
   );
   nco_amp_detector #(.DAC_WIDTH(DW), .IN_WIDTH(IW), .WIN_LOG2(2)) u_dut4 (
      .clk(clk), .rst(rst), .bus(b1)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (per instance) ----------------
   int     wl[2] = '{16, 4};
   int     m_cnt[2], m_run[2], m_ppeak[2], m_pfrac[2];
   bit     m_pend[2], m_psat[2];
   longint m_due[2];
   int     e_peak[2], e_frac[2];
   bit     e_sat[2], e_amp[2], e_busy[2], e_ovr[2];
   int     o_peak[2], o_frac[2];
   bit     o_sat[2], o_amp[2], o_busy[2], o_ovr[2];

   function automatic int abs_sat(input int x);
      if (x >= 0) return x;
      if (x == DNEG) return DMAX;
      return -x;
   endfunction

   function automatic int rnd_between(input int lo, input int hi);
      return lo + int'($urandom_range(0, hi - lo));
   endfunction

   function automatic void model_reset(input int i);
      m_cnt[i] = 0;  m_run[i] = 0;  m_pend[i] = 0;  m_due[i] = 0;
      e_peak[i] = 0; e_frac[i] = 0; e_sat[i] = 0; e_amp[i] = 0; e_busy[i] = 0; e_ovr[i] = 0;
   endfunction

   // Window rule: a window closing at clock edge e yields a pulse visible just after edge
   // e+IN_WIDTH (the cycle IN_WIDTH+1 after the one carrying the last sample). The unit is
   // occupied until that pulse; a window closing while occupied (including the pulse edge) is lost.
   function automatic void model_edge(input int i, input bit v, input int d, input int mv);
      bit wend;
      int snap;
      wend = 0;
      snap = 0;
      e_amp[i] = 0;
      if (rst) begin
         model_reset(i);
         return;
      end
      if (v) begin
         if (abs_sat(d) > m_run[i]) m_run[i] = abs_sat(d);
         m_cnt[i]++;
         if (m_cnt[i] == wl[i]) begin
            wend = 1; snap = m_run[i]; m_run[i] = 0; m_cnt[i] = 0;
         end
      end
      if (wend && m_pend[i]) begin
         e_ovr[i] = 1;
         wend = 0;
      end
      if (m_pend[i] && m_due[i] == cyc) begin
         e_peak[i] = m_ppeak[i]; e_frac[i] = m_pfrac[i]; e_sat[i] = m_psat[i];
         e_amp[i] = 1; m_pend[i] = 0;
      end
      if (wend) begin
         m_pend[i]  = 1;
         m_due[i]   = cyc + IW;
         m_ppeak[i] = snap;
         if (mv <= 0 || snap >= mv) begin
            m_pfrac[i] = FMAX; m_psat[i] = 1;
         end else begin
            m_pfrac[i] = (snap * FS) / mv; m_psat[i] = 0;
         end
      end
      e_busy[i] = m_pend[i];
   endfunction

   // Drive one cycle, advance the model at the edge, then observe both DUTs 1 time unit later.
   task automatic cycle(input bit v, input int d, input int mv);
      b0.ADC_VALID = v; b0.ADC_DATA = DW'(d); b0.MAX_VOLTAGE = DW'(mv);
      b1.ADC_VALID = v; b1.ADC_DATA = DW'(d); b1.MAX_VOLTAGE = DW'(mv);
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) model_edge(i, v, d, mv);
      #1;
      o_peak[0] = int'(b0.PEAK); o_frac[0] = int'(b0.FRAC); o_sat[0] = b0.SAT;
      o_amp[0]  = b0.AMP_VALID;  o_busy[0] = b0.BUSY;       o_ovr[0] = b0.OVERRUN;
      o_peak[1] = int'(b1.PEAK); o_frac[1] = int'(b1.FRAC); o_sat[1] = b1.SAT;
      o_amp[1]  = b1.AMP_VALID;  o_busy[1] = b1.BUSY;       o_ovr[1] = b1.OVERRUN;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      rst = 1'b0;
   endtask

   // Idle until the 16-window instance pulses; lat = edges waited, -1 if the bound expires.
   task automatic wait_amp(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         cycle(0, 0, 8000);
         if (o_amp[0]) begin
            lat = k;
            return;
         end
      end
   endtask

   // One 16-sample window whose largest magnitude comes from sample x at a random slot.
   task automatic send_window(input int x, input int mv);
      int pos, p;
      pos = rnd_between(0, 15);
      p   = abs_sat(x);
      for (int k = 0; k < 16; k++)
         cycle(1, (k == pos) ? x : rnd_between(-(p - 1), p - 1), mv);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (o_peak[i] !== 0 || o_frac[i] !== 0 || o_sat[i] !== 0 || o_amp[i] !== 0 ||
             o_busy[i] !== 0 || o_ovr[i] !== 0) begin
            errors++;
            $display("FAIL reset_state inst%0d: PEAK=%0d FRAC=%0d SAT=%0d AMP_VALID=%0d BUSY=%0d OVERRUN=%0d, all required 0",
                     i, o_peak[i], o_frac[i], o_sat[i], o_amp[i], o_busy[i], o_ovr[i]);
         end
      end
   endtask

   task automatic test_scaled_peak();
      int lat;
      do_reset();
      send_window(4000, 8000);
      wait_amp(lat);
      checks++;
      if (lat !== IW) begin
         errors++;
         $display("FAIL latency: got %0d edges after last sample, required %0d", lat, IW);
      end
      checks++;
      if (o_peak[0] !== 4000 || o_frac[0] !== 4096 || o_sat[0] !== 0) begin
         errors++;
         $display("FAIL scaled_peak: PEAK=%0d FRAC=%0d SAT=%0d, required 4000 4096 0",
                  o_peak[0], o_frac[0], o_sat[0]);
      end
   endtask

   typedef struct { int mv; int x; } sat_case_t;

   task automatic test_saturation();
      sat_case_t cases[9];
      int lat, p, ef;
      bit es;
      cases = '{'{8000, DNEG}, '{0, 5000}, '{8000, -2000}, '{-500, 100}, '{3000, 3000},
                '{3000, -2999}, '{8191, 8191}, '{8191, 1}, '{DNEG, -7}};
      do_reset();
      foreach (cases[c]) begin
         send_window(cases[c].x, cases[c].mv);
         wait_amp(lat);
         p  = abs_sat(cases[c].x);
         es = (cases[c].mv <= 0) || (p >= cases[c].mv);
         ef = es ? FMAX : (p * FS) / cases[c].mv;
         checks++;
         if (lat !== IW) begin
            errors++;
            $display("FAIL sat_latency case%0d: got %0d, required %0d", c, lat, IW);
         end
         checks++;
         if (o_peak[0] !== p || o_frac[0] !== ef || o_sat[0] !== es) begin
            errors++;
            $display("FAIL saturation case%0d (MAXV=%0d x=%0d): PEAK=%0d FRAC=%0d SAT=%0d, required %0d %0d %0d",
                     c, cases[c].mv, cases[c].x, o_peak[0], o_frac[0], o_sat[0], p, ef, es);
         end
      end
   endtask

   task automatic test_valid_toggle();
      int pulses;
      do_reset();
      pulses = 0;
      for (int k = 0; k < 116; k++) begin
         cycle((k < 96) && (k % 2 == 0), rnd_between(-6000, 6000), rnd_between(1000, 8191));
         if (o_amp[0]) pulses++;
         checks++;
         if (o_amp[0] !== e_amp[0] || o_peak[0] !== e_peak[0] || o_frac[0] !== e_frac[0] ||
             o_sat[0] !== e_sat[0]) begin
            errors++;
            $display("FAIL valid_toggle k=%0d: AMP_VALID=%0d PEAK=%0d FRAC=%0d SAT=%0d, required %0d %0d %0d %0d",
                     k, o_amp[0], o_peak[0], o_frac[0], o_sat[0], e_amp[0], e_peak[0], e_frac[0], e_sat[0]);
         end
      end
      checks++;
      if (pulses !== 3) begin
         errors++;
         $display("FAIL valid_toggle_count: got %0d pulses, required 3", pulses);
      end
   endtask

   task automatic test_reset_mid_divide();
      int lat, seen;
      do_reset();
      send_window(7000, 8000);
      for (int k = 0; k < 5; k++) cycle(1, -7000, 8000);
      checks++;
      if (o_busy[0] !== 1) begin
         errors++;
         $display("FAIL busy_in_divide: BUSY=%0d, required 1", o_busy[0]);
      end
      rst = 1'b1;
      cycle(1, 7000, 8000);
      rst = 1'b0;
      checks++;
      if (o_peak[0] !== 0 || o_frac[0] !== 0 || o_sat[0] !== 0 || o_amp[0] !== 0 ||
          o_busy[0] !== 0 || o_ovr[0] !== 0) begin
         errors++;
         $display("FAIL reset_mid_divide: PEAK=%0d FRAC=%0d SAT=%0d AMP_VALID=%0d BUSY=%0d OVERRUN=%0d, all required 0",
                  o_peak[0], o_frac[0], o_sat[0], o_amp[0], o_busy[0], o_ovr[0]);
      end
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(0, 0, 8000);
         if (o_amp[0]) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL aborted_pulse: got %0d AMP_VALID pulses after reset, required 0", seen);
      end
      send_window(-3000, 6000);
      wait_amp(lat);
      checks++;
      if (lat !== IW || o_peak[0] !== 3000 || o_frac[0] !== 4096 || o_sat[0] !== 0) begin
         errors++;
         $display("FAIL post_reset_window: latency=%0d PEAK=%0d FRAC=%0d SAT=%0d, required %0d 3000 4096 0",
                  lat, o_peak[0], o_frac[0], o_sat[0], IW);
      end
   endtask

   task automatic test_overrun();
      bit ea0, ea1, eo1;
      do_reset();
      for (int k = 1; k <= 60; k++) begin
         cycle(1, rnd_between(-8000, 8000), 8000);
         ea1 = (k == 18) || (k == 34) || (k == 50);
         eo1 = (k >= 8);
         ea0 = (k == 30) || (k == 46);
         checks++;
         if (o_amp[1] !== ea1 || o_ovr[1] !== eo1 || o_amp[0] !== ea0 || o_ovr[0] !== 0) begin
            errors++;
            $display("FAIL overrun k=%0d: win4 AMP_VALID=%0d OVERRUN=%0d win16 AMP_VALID=%0d OVERRUN=%0d, required %0d %0d %0d 0",
                     k, o_amp[1], o_ovr[1], o_amp[0], o_ovr[0], ea1, eo1, ea0);
         end
         if (o_amp[1]) begin
            checks++;
            if (o_peak[1] !== e_peak[1] || o_frac[1] !== e_frac[1] || o_sat[1] !== e_sat[1]) begin
               errors++;
               $display("FAIL overrun_result k=%0d: PEAK=%0d FRAC=%0d SAT=%0d, required %0d %0d %0d",
                        k, o_peak[1], o_frac[1], o_sat[1], e_peak[1], e_frac[1], e_sat[1]);
            end
         end
      end
   endtask

   task automatic test_random();
      int lim, d, mv;
      do_reset();
      lim = DMAX;
      for (int k = 0; k < 1500; k++) begin
         if (k % 64 == 0) lim = rnd_between(1, DMAX);
         d  = ($urandom_range(0, 39) == 0) ? DNEG : rnd_between(-lim, lim);
         case ($urandom_range(0, 9))
            0:       mv = 0;
            1:       mv = rnd_between(DNEG, -1);
            default: mv = rnd_between(1, DMAX);
         endcase
         cycle($urandom_range(0, 9) < 8, d, mv);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_amp[i] !== e_amp[i] || o_busy[i] !== e_busy[i] || o_ovr[i] !== e_ovr[i] ||
                o_peak[i] !== e_peak[i] || o_frac[i] !== e_frac[i] || o_sat[i] !== e_sat[i]) begin
               errors++;
               $display("FAIL random k=%0d inst%0d: AMP=%0d BUSY=%0d OVR=%0d PEAK=%0d FRAC=%0d SAT=%0d, required %0d %0d %0d %0d %0d %0d",
                        k, i, o_amp[i], o_busy[i], o_ovr[i], o_peak[i], o_frac[i], o_sat[i],
                        e_amp[i], e_busy[i], e_ovr[i], e_peak[i], e_frac[i], e_sat[i]);
            end
         end
      end
   endtask

   initial begin
      b0.ADC_VALID = 1'b0; b0.ADC_DATA = '0; b0.MAX_VOLTAGE = '0;
      b1.ADC_VALID = 1'b0; b1.ADC_DATA = '0; b1.MAX_VOLTAGE = '0;
      for (int i = 0; i < 2; i++) model_reset(i);
      test_reset();
      test_scaled_peak();
      test_saturation();
      test_valid_toggle();
      test_reset_mid_divide();
      test_overrun();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
